uart_tx_stream: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_tx_stream.sv | 116 +++++++++++
 tb/tb_uart_tx_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions (frame shape, FSM state codes, bit timing) for the host transmitter and command receiver.
// Constants and functions only: no latency, no flow control.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pop_data shows the head combinationally, a push is poppable the next cycle.
// Backpressure: push is ignored when full and pop is ignored when empty; simultaneous push and pop keep count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, registered uart_tx; a byte into an empty idle path starts its start bit one edge later.
// Backpressure: in_ready drops only while FIFO_DEPTH bytes are queued; queued frames follow each other with no idle gap.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST    = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST    = 3'(STOP_BITS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             bit_done;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dat;

  assign in_ready = !fifo_full;
  assign uart_tx  = tx_q;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);
  assign bit_done = (baud_cnt == CNT_LAST);
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_STOP && bit_done && bit_idx == STOP_LAST));

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid && in_ready),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else if (fifo_pop) begin
      // Shared by the idle start and the zero-gap restart at the end of a stop bit.
      state    <= ST_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= fifo_dat;
      tx_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              tx_q    <= 1'b1;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) state <= ST_IDLE;
            else                      bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: a frame-position model (byte queue + cycle offset into the frame) predicts every output each cycle,
// and an independent line decoder recovers transmitted bytes for order/loss checks.
module tb_uart_tx_stream;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_stream #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: queued bytes plus the cycle offset (pos) into the frame on the line; pos = -1 when idle.
  logic [7:0] mq[$];
  logic [7:0] acc_log[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;
  int         n_acc = 0;
  int         n_sent = 0;

  initial forever begin
    int  pre;
    logic acc;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      pos = -1;
    end else begin
      pre = mq.size();
      acc = in_valid && (pre < DEPTH);
      if (pos >= 0) begin
        pos++;
        if (pos == FRAME) pos = -1;
      end
      if (pos < 0 && pre > 0) begin
        cur = mq.pop_front();
        pos = 0;
        n_sent++;
      end
      if (acc) begin
        mq.push_back(in_data);
        acc_log.push_back(in_data);
        n_acc++;
      end
    end
  end

  function automatic int model_tx();
    int seg;
    if (pos < 0) return 1;
    seg = pos / CPB;
    if (seg == 0) return 0;
    if (seg == 9) return 1;
    return int'(cur[seg-1]);
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_tx",    int'(uart_tx),    1);
      chk("rst_busy",  int'(busy),       0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ready", int'(in_ready),   1);
    end else begin
      chk("tx",    int'(uart_tx),    model_tx());
      chk("count", int'(fifo_count), mq.size());
      chk("ready", int'(in_ready),   int'(mq.size() < DEPTH));
      chk("busy",  int'(busy),       int'(pos >= 0 || mq.size() != 0));
    end
  end

  // Line decoder: samples mid-bit relative to the detected start edge.
  int         rx_t = -1;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) rx_t = -1;
    else if (rx_t < 0) begin
      if (uart_tx == 1'b0) rx_t = 0;
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
        rx_sh[rx_t / CPB - 1] = uart_tx;
      if (rx_t == FRAME - CPB / 2) begin
        chk("rx_stop_bit", int'(uart_tx), 1);
        rx_q.push_back(rx_sh);
      end
      if (rx_t == FRAME - 1) rx_t = -1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (!(pos < 0 && mq.size() == 0) && n < limit) begin
      step();
      n++;
    end
    chk(name, int'(n < limit), 1);
  endtask

  initial begin
    logic [9:0] a5_line;
    logic [7:0] ex[$];
    logic [7:0] d;
    logic [7:0] drv;
    int acc0, s0, a0, r0, pa, to, run, maxrun, lows;

    // Reset with random inputs, then an idle line.
    repeat (6) begin
      step();
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
    end
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (50) step();
    chk("idle_line_high", int'(uart_tx), 1);
    chk("idle_count",     int'(fifo_count), 0);

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop.
    a5_line  = 10'b1101001010;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("a5_line_before_latency", int'(uart_tx), 1);
    for (int j = 1; j <= 101; j++) begin
      step();
      if (j == 1) chk("a5_start_latency", int'(uart_tx), 0);
      if (j % 10 == 5) chk($sformatf("a5_seg%0d", j / 10), int'(uart_tx), int'(a5_line[j / 10]));
      if (j == 100) chk("a5_busy_last_cycle", int'(busy), 1);
    end
    chk("a5_busy_done", int'(busy), 0);

    // Back-to-back 0x00 then 0xFF.
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    run = 0; maxrun = 0; lows = 0;
    repeat (205) begin
      if (!uart_tx) begin
        run++;
        lows++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      step();
    end
    chk("b2b_low_run",   maxrun, 90);
    chk("b2b_low_total", lows,   100);
    chk("b2b_idle",      int'(busy), 0);

    // Full FIFO with producer holding data; data churns while in_ready is low.
    acc0 = n_acc; s0 = n_sent; r0 = rx_q.size();
    ex.delete();
    d = 8'h00; in_data = d; in_valid = 1'b1; to = 0;
    while (n_acc - acc0 < 18 && to < 400) begin
      drv = in_data;
      pa  = n_acc;
      step();
      to++;
      if (n_acc != pa) begin
        ex.push_back(drv);
        d++;
        in_data = d;
      end else if (mq.size() >= DEPTH) in_data = 8'($urandom);
      if (to == 60) begin
        chk("full_accepted", n_acc - acc0, 17);
        chk("full_count",    int'(fifo_count), 16);
        chk("full_ready",    int'(in_ready), 0);
      end
    end
    in_valid = 1'b0;
    chk("full_18th_in_time",          int'(to < 400), 1);
    chk("full_18th_after_first_frame", n_sent - s0, 2);
    wait_idle(2500, "full_drained");
    chk("full_rx_count", rx_q.size() - r0, 18);
    for (int i = 0; i < ex.size() && r0 + i < rx_q.size(); i++)
      chk($sformatf("full_rx_byte%0d", i), int'(rx_q[r0 + i]), int'(ex[i]));
    for (int i = 0; i < 17 && i < ex.size(); i++)
      chk($sformatf("full_order%0d", i), int'(ex[i]), i);

    // Random traffic.
    a0 = acc_log.size(); r0 = rx_q.size();
    repeat (400) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_idle(3000, "rand_drained");
    chk("rand_rx_count", rx_q.size() - r0, acc_log.size() - a0);
    for (int i = 0; a0 + i < acc_log.size() && r0 + i < rx_q.size(); i++)
      chk("rand_rx_byte", int'(rx_q[r0 + i]), int'(acc_log[a0 + i]));

    // Reset during bit3 of a frame with 5 bytes queued.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i * 16);
      step();
    end
    in_valid = 1'b0;
    chk("mid_queued", int'(fifo_count), 5);
    to = 0;
    while (pos != 43 && to < 200) begin
      step();
      to++;
    end
    chk("mid_reached_bit3", int'(to < 200), 1);
    chk("mid_bit3_low", int'(uart_tx), 0);
    s0 = n_sent; r0 = rx_q.size();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",    int'(uart_tx),    1);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy",  int'(busy),       0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (300) step();
    chk("mid_no_frames",  n_sent - s0, 0);
    chk("mid_rx_none",    rx_q.size() - r0, 0);
    chk("mid_count_zero", int'(fifo_count), 0);
    chk("mid_line_high",  int'(uart_tx), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
